pipe_addsub: RTL and testbench

//   Parametrised, pipelined add/subtract unit for the datapath ALU and address paths.

---
 rtl/pipe_addsub.sv | 145 ++++++++++++++
 tb/tb_pipe_addsub.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_addsub
//  Description : Pipelined add/subtract unit. The WIDTH-bit add is split into
//                STAGES carry-chained slices, one slice per register stage.
//                Produces carry, signed-overflow and zero flags. Uses a
//                valid/ready handshake with full-pipeline stall and a flush.
//  Revision    : 1.0  initial release
// ============================================================================
//  WIDTH must be an exact multiple of STAGES (1 <= STAGES <= WIDTH).
// ============================================================================
module pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             carry,
   output logic             ovf,
   output logic             zero,
   output logic [TAG_W-1:0] tag_out
);

   localparam int c_cw = WIDTH / STAGES;   // slice width handled per stage

   // The whole pipeline moves together; a stalled result freezes every stage.
   logic w_adv;
   assign w_adv    = !out_valid | out_ready;
   assign in_ready = w_adv & !flush;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Operand bits not yet added when entering this stage, and result bits
      // complete after this stage.
      localparam int c_inw  = WIDTH - k * c_cw;
      localparam int c_resw = (k + 1) * c_cw;

      logic [c_inw-1:0]  w_ain;
      logic [c_inw-1:0]  w_bin;    // already conditionally inverted for sub
      logic              w_cin;
      logic              w_vin;
      logic [TAG_W-1:0]  w_tin;
      logic [c_cw-1:0]   w_sum;
      logic              w_cout;
      logic [c_resw-1:0] w_res;

      logic              r_v;
      logic [c_resw-1:0] r_s;
      logic              r_c;
      logic [TAG_W-1:0]  r_tag;

      if (k == 0) begin : g_first
         // Subtraction is a + ~b + 1: invert b once here, inject the +1 as cin.
         assign w_ain = a;
         assign w_bin = b ^ {WIDTH{sub}};
         assign w_cin = sub;
         assign w_vin = in_valid;
         assign w_tin = tag_in;
         assign w_res = w_sum;
      end else begin : g_next
         assign w_ain = g_stage[k-1].g_fwd.r_a;
         assign w_bin = g_stage[k-1].g_fwd.r_b;
         assign w_cin = g_stage[k-1].r_c;
         assign w_vin = g_stage[k-1].r_v;
         assign w_tin = g_stage[k-1].r_tag;
         assign w_res = {w_sum, g_stage[k-1].r_s};
      end

      assign {w_cout, w_sum} = {1'b0, w_ain[c_cw-1:0]}
                             + {1'b0, w_bin[c_cw-1:0]}
                             + {{c_cw{1'b0}}, w_cin};

      // Stage register: valid bit is killed by flush, data only moves on advance.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_v   <= 1'b0;
            r_s   <= '0;
            r_c   <= 1'b0;
            r_tag <= '0;
         end else begin
            if (flush) begin
               r_v <= 1'b0;
            end else if (w_adv) begin
               r_v <= w_vin;
            end
            if (w_adv) begin
               r_s   <= w_res;
               r_c   <= w_cout;
               r_tag <= w_tin;
            end
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [c_inw-c_cw-1:0] r_a;
         logic [c_inw-c_cw-1:0] r_b;

         // Carry the still-unprocessed upper operand slices forward.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv) begin
               r_a <= w_ain[c_inw-1:c_cw];
               r_b <= w_bin[c_inw-1:c_cw];
            end
         end
      end else begin : g_last
         logic r_ovf;
         logic r_zero;

         // Flags are built from the final slice so they always belong to the
         // same operation as the registered result.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_ovf  <= 1'b0;
               r_zero <= 1'b0;
            end else if (w_adv) begin
               r_ovf  <= (w_ain[c_cw-1] == w_bin[c_cw-1]) &
                         (w_sum[c_cw-1] != w_ain[c_cw-1]);
               r_zero <= ~|w_res;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].r_v;
   assign s         = g_stage[STAGES-1].r_s;
   assign carry     = g_stage[STAGES-1].r_c;
   assign tag_out   = g_stage[STAGES-1].r_tag;
   assign ovf       = g_stage[STAGES-1].g_last.r_ovf;
   assign zero      = g_stage[STAGES-1].g_last.r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_addsub
//  Description : Scoreboard bench for pipe_addsub. Four instances (STAGES =
//                2, 1, 4, 32) share one stimulus stream; each keeps its own
//                queue of expected results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_addsub;

   localparam int W    = 32;
   localparam int TW   = 5;
   localparam int NDUT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          sub = 1'b0;
   logic          out_ready = 1'b1;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [TW-1:0] tag = '0;

   logic [NDUT-1:0] in_ready_v;
   logic [NDUT-1:0] out_valid_v;
   int              pending [NDUT];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [W-1:0]  s;
      logic          c;
      logic          o;
      logic          z;
      logic [TW-1:0] t;
   } res_t;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Whole-word reference for one operation.
   function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                  input logic fsub, input logic [TW-1:0] ft);
      res_t         r;
      logic [W-1:0] bp;
      logic [W:0]   sum;
      bp  = fsub ? ~fb : fb;
      sum = {1'b0, fa} + {1'b0, bp} + {{W{1'b0}}, fsub};
      r.s = sum[W-1:0];
      r.c = sum[W];
      r.o = (fa[W-1] == bp[W-1]) && (r.s[W-1] != fa[W-1]);
      r.z = (r.s == '0);
      r.t = ft;
      return r;
   endfunction

   for (genvar i = 0; i < NDUT; i++) begin : g_dut
      localparam int ST = (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 4 : 32;

      logic [W-1:0]  s;
      logic          carry;
      logic          ovf;
      logic          zero;
      logic          ir;
      logic          ov;
      logic [TW-1:0] to;
      res_t          q [$];
      res_t          held;
      res_t          exp_r;
      logic          stalled = 1'b0;

      pipe_addsub #(.WIDTH(W), .STAGES(ST), .TAG_W(TW)) u_dut (
         .clk(clk), .rst(rst), .flush(flush),
         .in_valid(in_valid), .in_ready(ir),
         .a(a), .b(b), .sub(sub), .tag_in(tag),
         .out_valid(ov), .out_ready(out_ready),
         .s(s), .carry(carry), .ovf(ovf), .zero(zero), .tag_out(to)
      );

      assign in_ready_v[i]  = ir;
      assign out_valid_v[i] = ov;

      // Monitor mid-cycle: decide what transfers at the coming edge.
      always @(negedge clk) begin
         if (!rst) begin
            if (stalled)
               check($sformatf("hold_st%0d", ST), {ov, s, carry, ovf, zero, to}, {1'b1, held});
            if (flush) begin
               q.delete();
            end else begin
               if (ov && out_ready) begin
                  check($sformatf("out_expected_st%0d", ST), 64'(q.size() != 0), 64'd1);
                  if (q.size() != 0) begin
                     exp_r = q.pop_front();
                     check($sformatf("out_st%0d", ST), {s, carry, ovf, zero, to}, exp_r);
                  end
               end
               if (in_valid && ir)
                  q.push_back(model(a, b, sub, tag));
            end
            stalled = ov && !out_ready && !flush;
            held    = {s, carry, ovf, zero, to};
            pending[i] = q.size();
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                        input logic ds, input logic [TW-1:0] dt);
      in_valid = 1'b1;
      a = da; b = db; sub = ds; tag = dt;
   endtask

   logic [W-1:0] va [6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'h12345678};
   logic [W-1:0] vb [6] = '{32'd1,        32'd1,        32'd5, 32'd1,        32'd1, 32'h0F0F0F0F};
   logic         vs [6] = '{1'b0,         1'b0,         1'b1,  1'b1,         1'b1,  1'b1};

   initial begin
      int  lat;
      int  idx;
      logic acc;

      // Reset: held for two edges.
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_out_valid", 64'(out_valid_v), 64'd0);
      check("rst_s", 64'(g_dut[0].s), 64'd0);
      check("rst_flags", {g_dut[0].carry, g_dut[0].ovf, g_dut[0].zero}, 64'd0);
      check("rst_tag", 64'(g_dut[0].to), 64'd0);
      check("rst_in_ready", 64'(in_ready_v), 64'hF);

      // Latency of the 2-stage unit: valid after the second edge.
      drive(va[0], vb[0], vs[0], 5'd0);
      next_cycle();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid_v[0] && lat < 50) begin
         next_cycle();
         lat++;
      end
      check("latency_st2", 64'(lat), 64'd2);
      repeat (3) next_cycle();

      // Directed add/sub corner cases, back to back.
      for (int k = 0; k < 6; k++) begin
         drive(va[k], vb[k], vs[k], 5'(k + 1));
         next_cycle();
      end
      in_valid = 1'b0;
      repeat (40) next_cycle();

      // Backpressure: 8 ops, consumer stalls in cycles 3..6.
      idx = 0;
      for (int c = 0; c < 60; c++) begin
         out_ready = !(c >= 3 && c <= 6);
         if (idx < 8) drive($urandom, $urandom, 1'($urandom), 5'(idx));
         else in_valid = 1'b0;
         @(negedge clk);
         acc = in_valid && in_ready_v[0];
         if (out_valid_v[0] && !out_ready)
            check("full_in_ready", 64'(in_ready_v[0]), 64'd0);
         next_cycle();
         if (acc) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_accepted", 64'(idx), 64'd8);
      repeat (40) next_cycle();

      // Flush: two ops in flight, then flush while in_valid is high.
      drive(32'd100, 32'd1, 1'b0, 5'd20);
      next_cycle();
      drive(32'd200, 32'd2, 1'b0, 5'd21);
      next_cycle();
      drive(32'd300, 32'd3, 1'b0, 5'd22);
      flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 64'(in_ready_v), 64'd0);
      next_cycle();
      flush = 1'b0;
      drive(32'd400, 32'd4, 1'b1, 5'd23);
      next_cycle();
      in_valid = 1'b0;
      repeat (40) next_cycle();
      check("flush_drained_st2", 64'(pending[0]), 64'd0);

      // Random sweep with stalls and rare flushes.
      for (int c = 0; c < 10000; c++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
         if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'd0;
         drive(ra, rb, 1'($urandom), 5'($urandom));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 499) == 0);
         next_cycle();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (80) next_cycle();
      for (int i = 0; i < NDUT; i++)
         check($sformatf("drain_dut%0d", i), 64'(pending[i]), 64'd0);
      check("drain_out_valid", 64'(out_valid_v), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
